// File: rtl/lu_sweep_checker.sv
// lu_sweep_checker: drives all 16 logic-unit input vectors,
// samples s after a settle window and grades it against the golden table.
module lu_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s,
  output logic        a,
  output logic        b,
  output logic        select,
  output logic        select_group,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic        fail,
  output logic [3:0]  first_fail_idx
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  HOLD     = 2'd1;
  localparam logic [1:0]  SAMPLE   = 2'd2;
  localparam logic [15:0] GOLDEN   = 16'hE817;
  localparam logic [3:0]  SETTLE_C = 4'(SETTLE);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  err_q, err_d;
  logic        fail_q, fail_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        done_q, done_d;

  // Next-state logic for the sweep sequencer and the result registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HOLD;
          idx_d   = 4'd0;
          cnt_d   = SETTLE_C;
          tbl_d   = 16'h0000;
          err_d   = 5'd0;
          fail_d  = 1'b0;
          ffi_d   = 4'd0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        tbl_d[idx_q] = s;
        if (s != GOLDEN[idx_q]) begin
          err_d = err_q + 5'd1;
          if (!fail_q) begin
            fail_d = 1'b1;
            ffi_d  = idx_q;
          end
        end
        if (idx_q == 4'd15) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = HOLD;
          idx_d   = idx_q + 4'd1;
          cnt_d   = SETTLE_C;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      tbl_q   <= 16'h0000;
      err_q   <= 5'd0;
      fail_q  <= 1'b0;
      ffi_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      done_q  <= done_d;
    end
  end

  assign {select_group, select, a, b} = idx_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign table_out      = tbl_q;
  assign err_count      = err_q;
  assign fail           = fail_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_lu_sweep_checker.sv
// tb_lu_sweep_checker: two checker instances (SETTLE 1 and 3) driving a
// modelled logic unit with injectable per-vector faults; scoreboard checked.
module tb_lu_sweep_checker;

  typedef struct packed {
    int          inst;
    int          k;
    logic [15:0] tbl;
    logic [4:0]  ec;
    logic        fl;
    logic [3:0]  ffi;
    logic [3:0]  ridx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start_w;
  logic [15:0] fmask;
  logic [1:0]  s_w, a_w, b_w, sel_w, sg_w, busy_w, done_w, fl_w;
  logic [15:0] tbl_w [2];
  logic [4:0]  ec_w [2];
  logic [3:0]  ffi_w [2];

  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  int   ndone [2];
  exp_t q [$];
  exp_t rest [2];

  // Logic unit behaviour: NAND, NOR, AND, OR chosen by the top two bits.
  function automatic logic lu_ref(input logic [3:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    case (v[3:2])
      2'd0:    return ~(x & y);
      2'd1:    return ~(x | y);
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic int span(input int g);
    return (g == 0) ? 32 : 64;
  endfunction

  function automatic exp_t mk(input int g, input int k,
                              input logic [15:0] m);
    exp_t r;
    r.inst = g;
    r.k    = k;
    for (int i = 0; i < 16; i++) r.tbl[i] = lu_ref(4'(i)) ^ m[i];
    r.ec  = 5'($countones(m));
    r.fl  = (m != 16'h0);
    r.ffi = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) r.ffi = 4'(i);
    r.ridx = 4'd15;
    return r;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      lu_sweep_checker #(.SETTLE(g == 0 ? 1 : 3)) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start_w[g]),
        .s(s_w[g]),
        .a(a_w[g]),
        .b(b_w[g]),
        .select(sel_w[g]),
        .select_group(sg_w[g]),
        .busy(busy_w[g]),
        .done(done_w[g]),
        .table_out(tbl_w[g]),
        .err_count(ec_w[g]),
        .fail(fl_w[g]),
        .first_fail_idx(ffi_w[g])
      );
      assign s_w[g] = lu_ref({sg_w[g], sel_w[g], a_w[g], b_w[g]})
                    ^ fmask[{sg_w[g], sel_w[g], a_w[g], b_w[g]}];
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int gi,
                     input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h",
               nm, gi, cyc, act, exp);
    end
  endtask

  // Monitor: compares every instance each cycle against the scoreboard.
  always @(negedge clk) begin
    for (int gi = 0; gi < 2; gi++) begin
      int          j;
      int          vl;
      exp_t        e;
      logic [3:0]  vi;
      logic [31:0] obs;
      vl  = span(gi) / 16;
      vi  = {sg_w[gi], sel_w[gi], a_w[gi], b_w[gi]};
      obs = {busy_w[gi], done_w[gi], vi, tbl_w[gi], ec_w[gi],
             fl_w[gi], ffi_w[gi]};
      if (!rst_n) begin
        chk("reset_zero", gi, obs, 32'h0);
        rest[gi] = '0;
        q.delete();
      end else if (q.size() != 0 && q[0].inst == gi) begin
        e = q[0];
        j = cyc - e.k;
        if (j >= 0) begin
          chk("drive_idx", gi, {28'h0, vi},
              (j / vl > 15) ? 32'd15 : 32'(j / vl));
          chk("busy", gi, {31'h0, busy_w[gi]}, {31'h0, j < span(gi)});
          if (j == span(gi)) begin
            chk("done_pulse", gi, {31'h0, done_w[gi]}, 32'd1);
            chk("table", gi, {16'h0, tbl_w[gi]}, {16'h0, e.tbl});
            chk("err_count", gi, {27'h0, ec_w[gi]}, {27'h0, e.ec});
            chk("fail", gi, {31'h0, fl_w[gi]}, {31'h0, e.fl});
            chk("first_idx", gi, {28'h0, ffi_w[gi]}, {28'h0, e.ffi});
            rest[gi] = e;
            ndone[gi]++;
            void'(q.pop_front());
          end else begin
            chk("no_early_done", gi, {31'h0, done_w[gi]}, 32'd0);
          end
        end
      end else begin
        e = rest[gi];
        chk("idle_hold", gi, obs,
            {1'b0, 1'b0, e.ridx, e.tbl, e.ec, e.fl, e.ffi});
      end
    end
  end

  task automatic wait_done(input int gi, input int t, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (ndone[gi] >= t) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic sweep(input int gi, input logic [15:0] m, input bit extra);
    int base;
    @(negedge clk);
    #1;
    base = ndone[gi];
    fmask = m;
    start_w[gi] = 1'b1;
    q.push_back(mk(gi, cyc + 1, m));
    @(negedge clk);
    #1;
    start_w[gi] = 1'b0;
    if (extra) begin
      repeat (3) begin
        repeat (4) @(negedge clk);
        #1;
        start_w[gi] = 1'b1;
        @(negedge clk);
        #1;
        start_w[gi] = 1'b0;
      end
    end
    wait_done(gi, base + 1, span(gi) + 10);
    repeat (3) @(negedge clk);
  endtask

  task automatic hold_sweep(input int gi, input logic [15:0] m);
    int base;
    int k;
    @(negedge clk);
    #1;
    base = ndone[gi];
    fmask = m;
    start_w[gi] = 1'b1;
    k = cyc + 1;
    q.push_back(mk(gi, k, m));
    q.push_back(mk(gi, k + span(gi) + 1, m));
    wait_done(gi, base + 1, span(gi) + 10);
    @(negedge clk);
    #1;
    start_w[gi] = 1'b0;
    wait_done(gi, base + 2, span(gi) + 10);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid(input logic [15:0] m);
    int k;
    @(negedge clk);
    #1;
    fmask = m;
    start_w[0] = 1'b1;
    k = cyc + 1;
    q.push_back(mk(0, k, m));
    @(negedge clk);
    #1;
    start_w[0] = 1'b0;
    for (int i = 0; i < 40 && cyc < k + 10; i++) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [15:0] gold;
    logic [15:0] swp;
    start_w = 2'b00;
    fmask   = 16'h0;
    ndone[0] = 0;
    ndone[1] = 0;
    rest[0] = '0;
    rest[1] = '0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    gold = 16'h0;
    swp  = 16'h0;
    for (int i = 0; i < 16; i++) begin
      gold[i] = lu_ref(4'(i));
      if (i >= 8) swp[i] = (i[1] & i[0]) != (i[1] | i[0]);
    end

    sweep(0, 16'h0, 1'b0);
    sweep(0, gold, 1'b0);
    sweep(0, ~gold, 1'b0);
    sweep(0, swp, 1'b0);
    sweep(0, 16'($urandom), 1'b1);
    hold_sweep(0, 16'($urandom));
    reset_mid(16'($urandom));
    sweep(0, 16'h0, 1'b0);
    sweep(1, 16'h0, 1'b0);
    sweep(1, 16'($urandom), 1'b1);
    hold_sweep(1, swp);
    for (int n = 0; n < 6; n++) begin
      sweep(int'($urandom_range(0, 1)), 16'($urandom), n[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
